// File: rtl/iram_loader_pkg.sv
// Shared types and constants for the boot-time instruction RAM loader.
package iram_loader_pkg;

   typedef enum logic [2:0] {
      ST_SYNC,
      ST_LEN,
      ST_DATA,
      ST_CSUM,
      ST_DONE,
      ST_ERR
   } state_t;

   localparam logic [31:0] MAGIC_DEFAULT = 32'h5652_5053;
   localparam int unsigned HDR_BYTES     = 4;

   // States in which the loader is willing to take a byte.
   function automatic logic st_accepts(input state_t s);
      return (s == ST_SYNC) || (s == ST_LEN) || (s == ST_DATA) || (s == ST_CSUM);
   endfunction

endpackage

// File: rtl/iram_loader_byte_pack4.sv
// Packs four consecutive bytes into one little-endian 32-bit word.
module byte_pack4
   import iram_loader_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        i_clr,
   input  logic        i_vld,
   input  logic [7:0]  i_dat,
   output logic [31:0] o_word,
   output logic        o_word_vld
);

   localparam logic [1:0] K_LAST = 2'(HDR_BYTES - 1);

   logic [1:0]  r_k;
   logic [23:0] r_bytes;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_k     <= 2'd0;
         r_bytes <= 24'd0;
      end else if (i_clr) begin
         r_k     <= 2'd0;
         r_bytes <= 24'd0;
      end else if (i_vld) begin
         r_k <= r_k + 2'd1;
         case (r_k)
            2'd0:    r_bytes[7:0]   <= i_dat;
            2'd1:    r_bytes[15:8]  <= i_dat;
            2'd2:    r_bytes[23:16] <= i_dat;
            default: ;
         endcase
      end
   end

   // The fourth byte is used directly so the word is ready on its accepting edge.
   assign o_word     = {i_dat, r_bytes};
   assign o_word_vld = i_vld && (r_k == K_LAST);

endmodule

// File: rtl/iram_loader.sv
// Boot loader: validates a MAGIC/N/data/checksum byte stream, writes iram, releases core reset.
// Optional inter-byte timeout is compiled in with LOADER_TIMEOUT_EN.
module iram_loader
   import iram_loader_pkg::*;
#(
   parameter int          ADDR_W      = 12,
   parameter logic [31:0] MAGIC       = MAGIC_DEFAULT,
   parameter int          TIMEOUT_CYC = 100000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              byte_vld_i,
   input  logic [7:0]        byte_dat_i,
   output logic              byte_rdy_o,
   output logic              iram_we_o,
   output logic [ADDR_W-1:0] iram_addr_o,
   output logic [31:0]       iram_wdata_o,
   output logic              core_rst_n_o,
   output logic              done_o,
   output logic              err_o
);

   localparam logic [32:0] CAPACITY = 33'd1 << ADDR_W;

   state_t            r_state;
   state_t            w_state_nxt;
   logic              r_rdy;
   logic              r_done;
   logic              r_err;
   logic              r_core_rst_n;
   logic              r_we;
   logic [ADDR_W-1:0] r_addr;
   logic [31:0]       r_wdata;
   logic [31:0]       r_shift;
   logic [31:0]       r_csum;
   logic [ADDR_W-1:0] r_widx;
   logic [ADDR_W-1:0] r_last;

   logic              w_acc;
   logic              w_pack_vld;
   logic              w_pack_clr;
   logic [31:0]       w_word;
   logic              w_word_vld;
   logic [31:0]       w_shift_nxt;
   logic              w_len_over;
   logic              w_wr;
   logic              w_timeout;
   logic              w_rdy_nxt;
   logic              w_done_nxt;
   logic              w_err_nxt;
   logic              w_core_rst_n_nxt;

   assign w_acc       = byte_vld_i && r_rdy;
   assign w_pack_vld  = w_acc && (r_state != ST_SYNC);
   assign w_pack_clr  = (w_state_nxt != r_state);
   assign w_shift_nxt = {byte_dat_i, r_shift[31:8]};
   assign w_len_over  = {1'b0, w_word} > CAPACITY;
   assign w_wr        = w_word_vld && (r_state == ST_DATA);

   byte_pack4 u_pack (
      .clk        (clk),
      .rst        (rst),
      .i_clr      (w_pack_clr),
      .i_vld      (w_pack_vld),
      .i_dat      (byte_dat_i),
      .o_word     (w_word),
      .o_word_vld (w_word_vld)
   );

`ifdef LOADER_TIMEOUT_EN
   localparam int IDLE_W = $clog2(TIMEOUT_CYC + 1);

   logic [IDLE_W-1:0] r_idle;
   logic              w_idle_active;

   assign w_idle_active = (r_state == ST_LEN) || (r_state == ST_DATA) || (r_state == ST_CSUM);
   // An accepting cycle never times out, so a byte is never dropped by the abort.
   assign w_timeout     = w_idle_active && !w_acc && (r_idle >= IDLE_W'(TIMEOUT_CYC));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_idle <= '0;
      end else if (!w_idle_active || w_acc || w_timeout) begin
         r_idle <= '0;
      end else begin
         r_idle <= r_idle + IDLE_W'(1);
      end
   end
`else
   logic w_unused_timeout;

   assign w_timeout        = 1'b0;
   assign w_unused_timeout = ^TIMEOUT_CYC;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_SYNC;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_SYNC: begin
            if (w_acc && (w_shift_nxt == MAGIC)) w_state_nxt = ST_LEN;
         end
         ST_LEN: begin
            if (w_word_vld) begin
               if (w_len_over)          w_state_nxt = ST_ERR;
               else if (w_word == 32'd0) w_state_nxt = ST_CSUM;
               else                      w_state_nxt = ST_DATA;
            end
         end
         ST_DATA: begin
            if (w_word_vld && (r_widx == r_last)) w_state_nxt = ST_CSUM;
         end
         ST_CSUM: begin
            if (w_word_vld) w_state_nxt = (w_word == r_csum) ? ST_DONE : ST_ERR;
         end
         default: ;
      endcase
      if (w_timeout) w_state_nxt = ST_SYNC;
   end

   // Status outputs are registered from the next state, so they change on the deciding edge.
   always_comb begin
      w_rdy_nxt        = st_accepts(w_state_nxt);
      w_done_nxt       = (w_state_nxt == ST_DONE);
      w_err_nxt        = (w_state_nxt == ST_ERR);
      w_core_rst_n_nxt = (w_state_nxt == ST_DONE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rdy        <= 1'b0;
         r_done       <= 1'b0;
         r_err        <= 1'b0;
         r_core_rst_n <= 1'b0;
      end else begin
         r_rdy        <= w_rdy_nxt;
         r_done       <= w_done_nxt;
         r_err        <= w_err_nxt;
         r_core_rst_n <= w_core_rst_n_nxt;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_wdata <= 32'd0;
         r_shift <= 32'd0;
         r_csum  <= 32'd0;
         r_widx  <= '0;
         r_last  <= '0;
      end else begin
         r_we <= w_wr;
         if (w_wr) begin
            r_addr  <= r_widx;
            r_wdata <= w_word;
         end
         if (w_timeout) begin
            r_shift <= 32'd0;
            r_csum  <= 32'd0;
            r_widx  <= '0;
         end else begin
            if ((r_state == ST_SYNC) && w_acc) r_shift <= w_shift_nxt;
            // N is known to be 1..2**ADDR_W here, so N-1 always fits the index width.
            if ((r_state == ST_LEN) && w_word_vld) r_last <= w_word[ADDR_W-1:0] - ADDR_W'(1);
            if (w_wr) begin
               r_csum <= r_csum + w_word;
               if (r_widx != r_last) r_widx <= r_widx + ADDR_W'(1);
            end
         end
      end
   end

   assign byte_rdy_o   = r_rdy;
   assign iram_we_o    = r_we;
   assign iram_addr_o  = r_addr;
   assign iram_wdata_o = r_wdata;
   assign core_rst_n_o = r_core_rst_n;
   assign done_o       = r_done;
   assign err_o        = r_err;

endmodule

// File: tb/tb_iram_loader.sv
// Directed, table-driven bench for iram_loader (ADDR_W=4, TIMEOUT_CYC=50).
module tb_iram_loader;

   localparam int          AW    = 4;
   localparam logic [31:0] MAGIC = 32'h5652_5053;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          byte_vld_i = 1'b0;
   logic [7:0]    byte_dat_i = 8'd0;
   logic          byte_rdy_o;
   logic          iram_we_o;
   logic [AW-1:0] iram_addr_o;
   logic [31:0]   iram_wdata_o;
   logic          core_rst_n_o;
   logic          done_o;
   logic          err_o;

   iram_loader #(.ADDR_W(AW), .MAGIC(MAGIC), .TIMEOUT_CYC(50)) dut (
      .clk          (clk),
      .rst          (rst),
      .byte_vld_i   (byte_vld_i),
      .byte_dat_i   (byte_dat_i),
      .byte_rdy_o   (byte_rdy_o),
      .iram_we_o    (iram_we_o),
      .iram_addr_o  (iram_addr_o),
      .iram_wdata_o (iram_wdata_o),
      .core_rst_n_o (core_rst_n_o),
      .done_o       (done_o),
      .err_o        (err_o)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int gap_cyc = 0;

   logic [AW-1:0] log_addr [256];
   logic [31:0]   log_data [256];
   int            wr_total = 0;

   always @(negedge clk) begin
      if (!rst && iram_we_o) begin
         log_addr[wr_total[7:0]] = iram_addr_o;
         log_data[wr_total[7:0]] = iram_wdata_o;
         wr_total = wr_total + 1;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Status vector {rdy, we, core_rst_n, done, err}
   function automatic logic [4:0] status();
      return {byte_rdy_o, iram_we_o, core_rst_n_o, done_o, err_o};
   endfunction

   task automatic send_byte(input logic [7:0] b);
      int n;
      if (gap_cyc > 0) begin
         byte_vld_i = 1'b0;
         repeat (gap_cyc) @(negedge clk);
      end
      byte_vld_i = 1'b1;
      byte_dat_i = b;
      n = 0;
      while (!byte_rdy_o && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!byte_rdy_o) begin
         chk("byte_rdy_o wait", {31'd0, byte_rdy_o}, 32'd1);
         byte_vld_i = 1'b0;
         return;
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic send_word(input logic [31:0] w);
      for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
   endtask

   task automatic do_reset();
      @(negedge clk);
      byte_vld_i = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("reset status", {27'd0, status()}, 32'd0);
      chk("reset addr", {28'd0, iram_addr_o}, 32'd0);
      chk("reset wdata", iram_wdata_o, 32'd0);
      rst = 1'b0;
      chk("rdy low at release", {31'd0, byte_rdy_o}, 32'd0);
      @(negedge clk);
      chk("rdy high after release", {31'd0, byte_rdy_o}, 32'd1);
   endtask

   task automatic chk_writes(input string name, input int base, input int n,
                             input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2);
      logic [31:0] ew;
      chk({name, " write count"}, wr_total - base, n);
      for (int i = 0; i < n && i < 3; i++) begin
         ew = (i == 0) ? w0 : (i == 1) ? w1 : w2;
         chk({name, " addr"}, {28'd0, log_addr[(base + i) % 256]}, i);
         chk({name, " data"}, log_data[(base + i) % 256], ew);
      end
   endtask

   typedef struct {
      string       name;
      logic [31:0] len;
      logic [31:0] w0, w1, w2;
      logic [31:0] csum;
      bit          body;
      int          gap;
      int          exp_wr;
      bit          exp_done;
   } vec_t;

   vec_t tv [5];
   logic [7:0] q [$];
   int base;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // 0x13 + 0x00100093 + 0xDEADBEEF = 0xDEBDBF95 (mod 2**32)
      tv[0] = '{"nominal",  32'd3,  32'h0000_0013, 32'h0010_0093, 32'hDEAD_BEEF, 32'hDEBD_BF95, 1'b1, 0, 3, 1'b1};
      tv[1] = '{"bad csum", 32'd2,  32'h1,         32'h2,         32'h0,         32'h4,         1'b1, 0, 2, 1'b0};
      tv[2] = '{"zero len", 32'd0,  32'h0,         32'h0,         32'h0,         32'h0,         1'b1, 0, 0, 1'b1};
      tv[3] = '{"oversize", 32'd17, 32'h0,         32'h0,         32'h0,         32'h0,         1'b0, 0, 0, 1'b0};
      tv[4] = '{"gapped",   32'd2,  32'h8000_0001, 32'h8000_0002, 32'h0,         32'h0000_0003, 1'b1, 5, 2, 1'b1};

      for (int r = 0; r < 5; r++) begin
         do_reset();
         base = wr_total;
         gap_cyc = tv[r].gap;
         q.delete();
         for (int i = 0; i < 4; i++) q.push_back(MAGIC[8*i +: 8]);
         for (int i = 0; i < 4; i++) q.push_back(tv[r].len[8*i +: 8]);
         if (tv[r].body) begin
            for (int i = 0; i < 4 && tv[r].len > 0; i++) q.push_back(tv[r].w0[8*i +: 8]);
            for (int i = 0; i < 4 && tv[r].len > 1; i++) q.push_back(tv[r].w1[8*i +: 8]);
            for (int i = 0; i < 4 && tv[r].len > 2; i++) q.push_back(tv[r].w2[8*i +: 8]);
            for (int i = 0; i < 4; i++) q.push_back(tv[r].csum[8*i +: 8]);
         end
         for (int k = 0; k < q.size(); k++) begin
            if (k == q.size() - 1)
               chk({tv[r].name, " pre-final done/err"}, {30'd0, done_o, err_o}, 32'd0);
            send_byte(q[k]);
         end
         byte_vld_i = 1'b0;
         gap_cyc = 0;
         chk({tv[r].name, " final status"}, {27'd0, status()},
             tv[r].exp_done ? 32'b00110 : 32'b00001);
         repeat (3) @(negedge clk);
         chk_writes(tv[r].name, base, tv[r].exp_wr, tv[r].w0, tv[r].w1, tv[r].w2);
      end

      // Resync: junk and a false MAGIC start before the real header
      do_reset();
      base = wr_total;
      send_byte(8'h11); send_byte(8'h22); send_byte(8'h53); send_byte(8'h50);
      chk("resync still hunting", {27'd0, status()}, 32'b10000);
      send_word(MAGIC); send_word(32'd1); send_word(32'hCAFE_BABE); send_word(32'hCAFE_BABE);
      byte_vld_i = 1'b0;
      chk("resync final status", {27'd0, status()}, 32'b00110);
      repeat (2) @(negedge clk);
      chk_writes("resync", base, 1, 32'hCAFE_BABE, 32'h0, 32'h0);

      // Full capacity: 16 words 0x100+i, sum 0x1078, last address 15
      do_reset();
      base = wr_total;
      send_word(MAGIC); send_word(32'd16);
      send_word(32'h100);
      chk("write latency we", {31'd0, iram_we_o}, 32'd1);
      chk("write latency addr", {28'd0, iram_addr_o}, 32'd0);
      for (int i = 1; i < 16; i++) send_word(32'h100 + i);
      chk("full last addr", {28'd0, iram_addr_o}, 32'd15);
      send_word(32'h0000_1078);
      byte_vld_i = 1'b0;
      chk("full final status", {27'd0, status()}, 32'b00110);
      repeat (4) @(negedge clk);
      chk("full write count", wr_total - base, 16);
      for (int i = 0; i < 16; i++) begin
         chk("full addr", {28'd0, log_addr[(base + i) % 256]}, i);
         chk("full data", log_data[(base + i) % 256], 32'h100 + i);
      end

      // Reset asserted mid-DATA between clock edges
      do_reset();
      send_word(MAGIC); send_word(32'd3); send_word(32'h0000_0013);
      send_byte(8'h93); send_byte(8'h00);
      byte_vld_i = 1'b0;
      #2 rst = 1'b1;
      #1;
      chk("abort status", {27'd0, status()}, 32'd0);
      chk("abort addr", {28'd0, iram_addr_o}, 32'd0);
      chk("abort wdata", iram_wdata_o, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      base = wr_total;
      send_word(MAGIC); send_word(32'd3);
      send_word(32'h0000_0013); send_word(32'h0010_0093); send_word(32'hDEAD_BEEF);
      send_word(32'hDEBD_BF95);
      byte_vld_i = 1'b0;
      chk("after abort status", {27'd0, status()}, 32'b00110);
      repeat (2) @(negedge clk);
      chk_writes("after abort", base, 3, 32'h0000_0013, 32'h0010_0093, 32'hDEAD_BEEF);

      // Long stall after two data bytes
      do_reset();
      base = wr_total;
      send_word(MAGIC); send_word(32'd1);
      send_byte(8'hDD); send_byte(8'hCC);
      byte_vld_i = 1'b0;
      repeat (60) @(negedge clk);
`ifdef LOADER_TIMEOUT_EN
      chk("timeout status", {27'd0, status()}, 32'b10000);
      chk("timeout no write", wr_total - base, 0);
      send_word(MAGIC); send_word(32'd1); send_word(32'h1234_5678); send_word(32'h1234_5678);
      byte_vld_i = 1'b0;
      chk("post-timeout status", {27'd0, status()}, 32'b00110);
      repeat (2) @(negedge clk);
      chk_writes("post-timeout", base, 1, 32'h1234_5678, 32'h0, 32'h0);
`else
      chk("stall status", {27'd0, status()}, 32'b10000);
      send_byte(8'hBB); send_byte(8'hAA);
      send_word(32'hAABB_CCDD);
      byte_vld_i = 1'b0;
      chk("stall final status", {27'd0, status()}, 32'b00110);
      repeat (2) @(negedge clk);
      chk_writes("stall", base, 1, 32'hAABB_CCDD, 32'h0, 32'h0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
